// File: rtl/debounce_pkg.sv
// Shared types and elaboration helpers for the multi-channel debouncer.
package debounce_pkg;

    typedef struct packed {
        logic rise;
        logic fall;
    } strobe_t;

    // DELAY and CLOCK_PERIOD share a time unit; the result rounds down.
    function automatic int unsigned count_cycles(input int unsigned delay, input int unsigned period);
        return delay / period;
    endfunction

    function automatic int count_width(input int unsigned count);
        return $clog2(count + 1);
    endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Pin-side bundle of the debouncer: raw inputs in, clean levels and edge strobes out.
interface debounce_multi_if #(
    parameter int unsigned CHANNELS = 4
);
    logic [CHANNELS-1:0] signal_in;
    logic [CHANNELS-1:0] signal_out;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;

    modport master (
        output signal_in,
        input  signal_out,
        input  rise,
        input  fall
    );

    modport slave (
        input  signal_in,
        output signal_out,
        output rise,
        output fall
    );
endinterface

// File: rtl/debounce_channel.sv
// Single-channel debouncer: synchroniser, stability counter, level register, edge strobes.
// Latency: SYNC_STAGES+COUNT edges from input change to level change; strobes align with it.
// No backpressure: free-running, one sample per clock.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned COUNT       = 10,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          RESET_VALUE = 1'b0
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    din,
    output logic    level,
    output strobe_t strobe
);
    localparam int           W    = count_width(COUNT);
    localparam logic [W-1:0] LAST = W'(COUNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [W-1:0]           cnt_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Chain preloads RESET_VALUE so a quiet input after reset looks like a real change.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            level  <= RESET_VALUE;
            strobe <= '0;
        end else begin
            strobe <= '0;
            if (s == level) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                cnt_q       <= '0;
                level       <= s;
                strobe.rise <= s;
                strobe.fall <= ~s;
            end else begin
                cnt_q <= cnt_q + W'(1);
            end
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: CHANNELS independent debounce_channel instances.
// Latency: SYNC_STAGES+COUNT edges per channel, COUNT = DELAY/CLOCK_PERIOD.
// No backpressure: outputs are levels and one-cycle strobes.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned         CHANNELS     = 4,
    parameter int unsigned         DELAY        = 10_000_000,
    parameter int unsigned         CLOCK_PERIOD = 20,
    parameter int unsigned         SYNC_STAGES  = 2,
    parameter logic [CHANNELS-1:0] RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset,
    debounce_multi_if.slave  bus
);
    localparam int unsigned COUNT = count_cycles(DELAY, CLOCK_PERIOD);

    if (COUNT < 1) begin : g_bad_count
        $error("debounce_multi: DELAY/CLOCK_PERIOD must be at least 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_multi: SYNC_STAGES must be at least 2");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("debounce_multi: CHANNELS must be at least 1");
    end

    logic [CHANNELS-1:0] level;
    strobe_t             strobe [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .COUNT       (COUNT),
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_VALUE (RESET_VALUE[i])
        ) u_channel (
            .clk    (clk),
            .reset  (reset),
            .din    (bus.signal_in[i]),
            .level  (level[i]),
            .strobe (strobe[i])
        );

        assign bus.rise[i] = strobe[i].rise;
        assign bus.fall[i] = strobe[i].fall;
    end

    assign bus.signal_out = level;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi with COUNT=10, SYNC_STAGES=2, RESET_VALUE=4'b0010.
module tb_debounce_multi;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    typedef struct {
        int         at;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    exp_t sb[$];

    debounce_multi_if #(.CHANNELS(4)) bus ();

    debounce_multi #(
        .CHANNELS     (4),
        .DELAY        (100),
        .CLOCK_PERIOD (10),
        .SYNC_STAGES  (2),
        .RESET_VALUE  (4'b0010)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Strobe scoreboard: every strobe must match the oldest pending expectation.
    task automatic monitor_strobes();
        logic [3:0] prev_rise;
        logic [3:0] prev_fall;
        exp_t       e;
        prev_rise = '0;
        prev_fall = '0;
        forever begin
            @(negedge clk);
            checks++;
            if ((bus.rise & bus.fall) !== 4'b0000) begin
                errors++;
                $display("FAIL rise_and_fall cyc=%0d rise=%b fall=%b required overlap 0000", cyc, bus.rise, bus.fall);
            end
            checks++;
            if (((bus.rise & prev_rise) | (bus.fall & prev_fall)) !== 4'b0000) begin
                errors++;
                $display("FAIL strobe_two_cycles cyc=%0d rise=%b fall=%b prev_rise=%b prev_fall=%b", cyc, bus.rise, bus.fall, prev_rise, prev_fall);
            end
            if ((bus.rise | bus.fall) !== 4'b0000) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe cyc=%0d rise=%b fall=%b required none", cyc, bus.rise, bus.fall);
                end else begin
                    e = sb.pop_front();
                    if (e.at != cyc || e.rise !== bus.rise || e.fall !== bus.fall) begin
                        errors++;
                        $display("FAIL strobe_match cyc=%0d rise=%b fall=%b required cyc=%0d rise=%b fall=%b", cyc, bus.rise, bus.fall, e.at, e.rise, e.fall);
                    end
                end
            end else if (sb.size() != 0 && sb[0].at < cyc) begin
                checks++;
                e = sb.pop_front();
                errors++;
                $display("FAIL missed_strobe cyc=%0d required at cyc=%0d rise=%b fall=%b", cyc, e.at, e.rise, e.fall);
            end
            prev_rise = bus.rise;
            prev_fall = bus.fall;
        end
    endtask

    task automatic test_reset();
        int c;
        reset = 1'b1;
        bus.signal_in = 4'b0000;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.signal_out !== 4'b0010 || bus.rise !== 4'b0000 || bus.fall !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state out=%b rise=%b fall=%b required out=0010 rise=0000 fall=0000", bus.signal_out, bus.rise, bus.fall);
        end
        reset = 1'b0;
        c = cyc;
        sb.push_back('{c + 12, 4'b0000, 4'b0010});
        wait_until(c + 11);
        checks++;
        if (bus.signal_out !== 4'b0010) begin
            errors++;
            $display("FAIL reset_release_hold out=%b required 0010", bus.signal_out);
        end
        wait_until(c + 12);
        checks++;
        if (bus.signal_out !== 4'b0000 || bus.fall !== 4'b0010) begin
            errors++;
            $display("FAIL reset_release_fall out=%b fall=%b required out=0000 fall=0010", bus.signal_out, bus.fall);
        end
        wait_until(c + 14);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL reset_pending got %0d required 0", sb.size());
        end
    endtask

    task automatic test_rise();
        int c;
        c = cyc;
        bus.signal_in[0] = 1'b1;
        sb.push_back('{c + 12, 4'b0001, 4'b0000});
        wait_until(c + 11);
        checks++;
        if (bus.signal_out !== 4'b0000) begin
            errors++;
            $display("FAIL rise_early out=%b required 0000", bus.signal_out);
        end
        wait_until(c + 12);
        checks++;
        if (bus.signal_out !== 4'b0001 || bus.rise !== 4'b0001) begin
            errors++;
            $display("FAIL rise_edge out=%b rise=%b required out=0001 rise=0001", bus.signal_out, bus.rise);
        end
        wait_until(c + 14);
        checks++;
        if (sb.size() != 0 || bus.signal_out !== 4'b0001) begin
            errors++;
            $display("FAIL rise_after pending=%0d out=%b required 0 and 0001", sb.size(), bus.signal_out);
        end
    endtask

    task automatic test_bounce();
        int c;
        c = cyc;
        bus.signal_in[2] = 1'b1;
        sb.push_back('{c + 15, 4'b0100, 4'b0000});
        wait_until(c + 2);
        bus.signal_in[2] = 1'b0;
        wait_until(c + 3);
        bus.signal_in[2] = 1'b1;
        wait_until(c + 12);
        checks++;
        if (bus.signal_out !== 4'b0001) begin
            errors++;
            $display("FAIL bounce_window out=%b required 0001", bus.signal_out);
        end
        wait_until(c + 14);
        checks++;
        if (bus.signal_out !== 4'b0001) begin
            errors++;
            $display("FAIL bounce_restart out=%b required 0001", bus.signal_out);
        end
        wait_until(c + 15);
        checks++;
        if (bus.signal_out !== 4'b0101 || bus.rise !== 4'b0100) begin
            errors++;
            $display("FAIL bounce_settle out=%b rise=%b required out=0101 rise=0100", bus.signal_out, bus.rise);
        end
        wait_until(c + 17);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL bounce_pending got %0d required 0", sb.size());
        end
    endtask

    task automatic test_short_pulse();
        int c;
        c = cyc;
        bus.signal_in[3] = 1'b1;
        wait_until(c + 9);
        bus.signal_in[3] = 1'b0;
        wait_until(c + 30);
        checks++;
        if (bus.signal_out !== 4'b0101) begin
            errors++;
            $display("FAIL pulse9_rejected out=%b required 0101", bus.signal_out);
        end
        c = cyc;
        bus.signal_in[3] = 1'b1;
        sb.push_back('{c + 12, 4'b1000, 4'b0000});
        sb.push_back('{c + 22, 4'b0000, 4'b1000});
        wait_until(c + 10);
        bus.signal_in[3] = 1'b0;
        wait_until(c + 12);
        checks++;
        if (bus.signal_out !== 4'b1101 || bus.rise !== 4'b1000) begin
            errors++;
            $display("FAIL pulse10_rise out=%b rise=%b required out=1101 rise=1000", bus.signal_out, bus.rise);
        end
        wait_until(c + 21);
        checks++;
        if (bus.signal_out !== 4'b1101) begin
            errors++;
            $display("FAIL pulse10_hold out=%b required 1101", bus.signal_out);
        end
        wait_until(c + 22);
        checks++;
        if (bus.signal_out !== 4'b0101 || bus.fall !== 4'b1000) begin
            errors++;
            $display("FAIL pulse10_fall out=%b fall=%b required out=0101 fall=1000", bus.signal_out, bus.fall);
        end
        wait_until(c + 24);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pulse_pending got %0d required 0", sb.size());
        end
    endtask

    task automatic test_simultaneous();
        int c;
        c = cyc;
        bus.signal_in = 4'b1010;
        sb.push_back('{c + 12, 4'b1010, 4'b0101});
        wait_until(c + 11);
        checks++;
        if (bus.signal_out !== 4'b0101) begin
            errors++;
            $display("FAIL simul_early out=%b required 0101", bus.signal_out);
        end
        wait_until(c + 12);
        checks++;
        if (bus.signal_out !== 4'b1010 || bus.rise !== 4'b1010 || bus.fall !== 4'b0101) begin
            errors++;
            $display("FAIL simul_edge out=%b rise=%b fall=%b required out=1010 rise=1010 fall=0101", bus.signal_out, bus.rise, bus.fall);
        end
        wait_until(c + 14);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL simul_pending got %0d required 0", sb.size());
        end
    endtask

    task automatic test_reset_midcount();
        int c;
        int c2;
        c = cyc;
        bus.signal_in[0] = 1'b1;
        wait_until(c + 9);
        reset = 1'b1;
        wait_until(c + 10);
        checks++;
        if (bus.signal_out !== 4'b0010 || bus.rise !== 4'b0000 || bus.fall !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_state out=%b rise=%b fall=%b required out=0010 rise=0000 fall=0000", bus.signal_out, bus.rise, bus.fall);
        end
        reset = 1'b0;
        c2 = cyc;
        sb.push_back('{c2 + 12, 4'b1001, 4'b0000});
        wait_until(c2 + 11);
        checks++;
        if (bus.signal_out !== 4'b0010) begin
            errors++;
            $display("FAIL midreset_hold out=%b required 0010", bus.signal_out);
        end
        wait_until(c2 + 12);
        checks++;
        if (bus.signal_out !== 4'b1011 || bus.rise !== 4'b1001) begin
            errors++;
            $display("FAIL midreset_relatch out=%b rise=%b required out=1011 rise=1001", bus.signal_out, bus.rise);
        end
        wait_until(c2 + 14);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL midreset_pending got %0d required 0", sb.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.signal_in = 4'b0000;
        fork
            monitor_strobes();
        join_none
        test_reset();
        test_rise();
        test_bounce();
        test_short_pulse();
        test_simultaneous();
        test_reset_midcount();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
